// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, fetch FSM states and the default reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection: jump beats taken branch, otherwise fall through to pc+4.
// Purely combinational so the pipelined core can reuse it unchanged.
module next_pc_logic (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] imm_ext,
  input  logic [25:0] instr_index,
  input  logic        branch_in,
  input  logic        zero_in,
  input  logic        jump_in,
  output logic [31:0] next_pc
);

  // Priority select; 32-bit adds drop the carry so the PC wraps naturally.
  always_comb begin
    next_pc = pc_plus4;
    if (jump_in) begin
      next_pc = {pc_plus4[31:28], instr_index, 2'b00};
    end else if (branch_in && zero_in) begin
      next_pc = pc_plus4 + (imm_ext << 2);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage of the single-cycle MIPS core: PC, instruction register,
// retired-instruction counter and the FETCH/EXEC sequencing FSM.
module instr_fetch
  import mips_pkg::*;
#(
  // Must be word-aligned; pc[1:0] stays 00 because every update is a multiple of 4.
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         branch_in,
  input  logic         zero_in,
  input  logic [31:0]  imm_ext,
  input  logic         jump_in,
  input  logic         hold_in,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr,
  output logic [5:0]   opcode,
  output logic         instr_valid,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  output logic [31:0]  instr_count,
  output fetch_state_t dbgState
);

  // Handshake: imem_req is high for the whole FETCH state with imem_addr
  // held at pc; a transfer happens on any rising edge where imem_req and
  // imem_ready are both high, and imem_rdata is captured on that same edge.
  // imem_ready is ignored whenever imem_req is low. A reset during FETCH
  // abandons the request without a transfer.

  fetch_state_t stateQ;
  logic [31:0]  nextPc;

  assign imem_req    = (stateQ == FETCH);
  assign instr_valid = (stateQ == EXEC);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign opcode      = instr[31:26];
  assign dbgState    = stateQ;

  next_pc_logic uNextPc (
    .pc_plus4    (pc_plus4),
    .imm_ext     (imm_ext),
    .instr_index (instr[25:0]),
    .branch_in   (branch_in),
    .zero_in     (zero_in),
    .jump_in     (jump_in),
    .next_pc     (nextPc)
  );

  // FSM plus PC/instruction/count registers; reset overrides any pending
  // handshake or retire in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= RESET;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      case (stateQ)
        RESET: begin
          stateQ <= FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            instr  <= imem_rdata;
            stateQ <= EXEC;
          end
        end
        EXEC: begin
          if (!hold_in) begin
            pc          <= nextPc;
            instr_count <= instr_count + 32'd1;
            stateQ      <= FETCH;
          end
        end
        default: begin
          stateQ <= RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed sequences, a next-PC vector
// table, and a randomized run against a transaction-level reference model.
module tb_instr_fetch;
  import mips_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic         clk;
  logic         rst;
  logic         branch_in;
  logic         zero_in;
  logic [31:0]  imm_ext;
  logic         jump_in;
  logic         hold_in;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ready;
  logic [31:0]  imem_rdata;
  logic [31:0]  instr;
  logic [5:0]   opcode;
  logic         instr_valid;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  instr_count;
  fetch_state_t dbgState;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] startPc;
    logic [31:0] instrWord;
    logic        br;
    logic        zr;
    logic        jp;
    logic [31:0] imm;
    logic [31:0] expNext;
  } vec_t;

  vec_t vecs[9];

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .branch_in   (branch_in),
    .zero_in     (zero_in),
    .imm_ext     (imm_ext),
    .jump_in     (jump_in),
    .hold_in     (hold_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_count (instr_count),
    .dbgState    (dbgState)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // advance one cycle; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    branch_in  = 1'b0;
    zero_in    = 1'b0;
    jump_in    = 1'b0;
    hold_in    = 1'b0;
    imm_ext    = 32'd0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
  endtask

  // reset, then retire one taken branch that lands on target (leaves DUT in FETCH at target)
  task automatic go_to_pc(input logic [31:0] target);
    clear_inputs();
    rst = 1'b1;
    step();
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h1000_0000;
    step();
    branch_in = 1'b1;
    zero_in   = 1'b1;
    imm_ext   = (target - 32'd4) >> 2;
    step();
    step();
    clear_inputs();
    chk("goto_pc", pc, target);
  endtask

  // high-level reference model state
  logic        mStarted;
  logic        mHave;
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mCount;

  function automatic logic [31:0] model_next(input logic [31:0] curPc, input logic [31:0] word,
                                             input logic br, input logic zr, input logic jp,
                                             input logic [31:0] imm);
    logic [31:0] seq;
    seq = curPc + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    if (br && zr) return seq + imm * 32'd4;
    return seq;
  endfunction

  initial begin
    rst = 1'b1;
    clear_inputs();

    vecs[0] = '{32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_000C};
    vecs[1] = '{32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0014};
    vecs[2] = '{32'h1000_0040, 32'h0800_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h1000_0400};
    vecs[3] = '{32'h1000_0040, 32'h0800_0100, 1'b1, 1'b1, 1'b1, 32'h0000_0005, 32'h1000_0400};
    vecs[4] = '{32'hFFFF_FFFC, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFFC, 32'h1000_0001, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0004};
    vecs[6] = '{32'hF000_0000, 32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC};
    vecs[7] = '{32'h0000_0100, 32'h2008_0005, 1'b0, 1'b1, 1'b0, 32'h0000_0007, 32'h0000_0104};
    vecs[8] = '{32'h0000_0100, 32'h1000_0007, 1'b1, 1'b1, 1'b0, 32'h0000_0007, 32'h0000_0120};

    // reset values
    step();
    step();
    chk("rst_req",   imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_op",    opcode, 0);
    chk("rst_pc",    pc, RPC);
    chk("rst_addr",  imem_addr, RPC);
    chk("rst_pc4",   pc_plus4, RPC + 32'd4);
    chk("rst_cnt",   instr_count, 0);
    chk("rst_state", dbgState, RESET);

    // release with memory always ready, addi
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h2008_0005;
    step();
    chk("c1_req",   imem_req, 1);
    chk("c1_addr",  imem_addr, 32'h0);
    chk("c1_valid", instr_valid, 0);
    step();
    chk("c2_valid", instr_valid, 1);
    chk("c2_op",    opcode, 6'b001000);
    chk("c2_instr", instr, 32'h2008_0005);
    chk("c2_req",   imem_req, 0);
    step();
    chk("c3_addr",  imem_addr, 32'h4);
    chk("c3_cnt",   instr_count, 1);
    chk("c3_req",   imem_req, 1);

    // ready delayed 3 cycles
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("dly_req_1",   imem_req, 1);
    chk("dly_addr_1",  imem_addr, 32'h0);
    chk("dly_valid_1", instr_valid, 0);
    for (int i = 2; i <= 4; i++) begin
      imem_rdata = $urandom;
      step();
      chk($sformatf("dly_req_%0d", i),   imem_req, 1);
      chk($sformatf("dly_addr_%0d", i),  imem_addr, 32'h0);
      chk($sformatf("dly_valid_%0d", i), instr_valid, 0);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h8C01_0004;
    step();
    chk("dly_valid_exec", instr_valid, 1);
    chk("dly_instr",      instr, 32'h8C01_0004);
    chk("dly_op",         opcode, OP_LW);

    // hold_in for 2 EXEC cycles
    clear_inputs();
    rst = 1'b1;
    step();
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h2008_0005;
    hold_in    = 1'b1;
    step();
    step();
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("hold_valid_%0d", i), instr_valid, 1);
      chk($sformatf("hold_pc_%0d", i),    pc, 32'h0);
      chk($sformatf("hold_cnt_%0d", i),   instr_count, 0);
      if (i == 3) hold_in = 1'b0;
      step();
    end
    chk("hold_valid_end", instr_valid, 0);
    chk("hold_cnt_end",   instr_count, 1);
    chk("hold_addr_end",  imem_addr, 32'h4);

    // reset mid-FETCH with ready in the same cycle
    rst        = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEC;
    step();
    chk("rf_pc",    pc, RPC);
    chk("rf_instr", instr, 0);
    chk("rf_cnt",   instr_count, 0);
    chk("rf_req",   imem_req, 0);
    chk("rf_valid", instr_valid, 0);
    rst = 1'b0;
    step();
    chk("rf_req_after", imem_req, 1);

    // reset in EXEC discards the instruction
    step();
    chk("re_valid", instr_valid, 1);
    rst = 1'b1;
    step();
    chk("re_pc",  pc, RPC);
    chk("re_cnt", instr_count, 0);
    rst = 1'b0;

    // next-PC vector table
    for (int v = 0; v < 9; v++) begin
      go_to_pc(vecs[v].startPc);
      imem_ready = 1'b1;
      imem_rdata = vecs[v].instrWord;
      step();
      chk($sformatf("vec%0d_op", v), opcode, vecs[v].instrWord >> 26);
      branch_in = vecs[v].br;
      zero_in   = vecs[v].zr;
      jump_in   = vecs[v].jp;
      imm_ext   = vecs[v].imm;
      step();
      chk($sformatf("vec%0d_next", v), imem_addr, vecs[v].expNext);
      chk($sformatf("vec%0d_pc4", v),  pc_plus4, vecs[v].expNext + 32'd4);
      clear_inputs();
    end

    // randomized run against the reference model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst        = (cyc == 0) || ($urandom_range(0, 63) == 0);
      imem_ready = ($urandom_range(0, 9) < 6);
      hold_in    = ($urandom_range(0, 9) < 3);
      jump_in    = ($urandom_range(0, 7) == 0);
      branch_in  = $urandom_range(0, 1);
      zero_in    = $urandom_range(0, 1);
      imm_ext    = $urandom;
      imem_rdata = $urandom;
      // scoreboard: each accepted fetch must use the next expected address
      if (!rst && imem_req && imem_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          chk("sb_fetch_addr", imem_addr, exp_q.pop_front());
        end
      end
      @(posedge clk);
      if (rst) begin
        mStarted = 1'b0;
        mHave    = 1'b0;
        mPc      = RPC;
        mInstr   = 32'd0;
        mCount   = 32'd0;
        exp_q.delete();
        exp_q.push_back(RPC);
      end else if (!mStarted) begin
        mStarted = 1'b1;
      end else if (!mHave) begin
        if (imem_ready) begin
          mInstr = imem_rdata;
          mHave  = 1'b1;
        end
      end else if (!hold_in) begin
        mPc    = model_next(mPc, mInstr, branch_in, zero_in, jump_in, imm_ext);
        mCount = mCount + 32'd1;
        mHave  = 1'b0;
        exp_q.push_back(mPc);
      end
      #1;
      chk("rnd_req",   imem_req, mStarted && !mHave);
      chk("rnd_valid", instr_valid, mHave);
      chk("rnd_pc",    pc, mPc);
      chk("rnd_addr",  imem_addr, mPc);
      chk("rnd_pc4",   pc_plus4, mPc + 32'd4);
      chk("rnd_instr", instr, mInstr);
      chk("rnd_op",    opcode, mInstr >> 26);
      chk("rnd_cnt",   instr_count, mCount);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MIPS single-cycle core: holds the program counter, fetches one 32-bit instruction per step from instruction memory over a req/ready handshake, and presents the instruction and its opcode to the control block and register file. At the end of each execute step it computes the next PC from the branch, zero and jump inputs that the control block and ALU return. A small FSM sequences fetch and execute. A retired-instruction counter is provided for debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- branch_in  in  1  Branch from control block; sampled only in EXEC.
- zero_in  in  1  ALU zero flag; sampled only in EXEC.
- imm_ext  in  32  sign-extended instr[15:0].
- jump_in  in  1  jump request (tied 0 until the control block decodes j).
- hold_in  in  1  datapath stall; keeps the stage in EXEC.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  in  32  instruction word; valid when imem_ready is high.
- instr  out  32  registered instruction.
- opcode  out  6  instr[31:26]; drives the control block.
- instr_valid  out  1  instr is current and may execute; datapath gates RegWrite/MemWrite with it.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4.
- instr_count  out  32  retired instructions.

## Operation
- FSM states: RESET, FETCH, EXEC.
- rst=1 forces the following on the next edge, whatever the current state:
  - state=RESET, pc=RESET_PC, instr=0, instr_count=0.
- RESET → FETCH on the first edge with rst=0. In RESET: imem_req=0, instr_valid=0.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ready.
  - On req&ready: instr<=imem_rdata, then go to EXEC. Otherwise stay in FETCH, with no timeout.
- EXEC:
  - instr_valid=1, imem_req=0.
  - If hold_in=1: stay in EXEC with pc and instr unchanged.
  - Else: pc<=next_pc, instr_count<=instr_count+1 (wraps modulo 2^32), then go to FETCH.
- next_pc, in priority order:
  - jump_in=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  - branch_in&zero_in: pc_plus4 + (imm_ext<<2)
  - otherwise: pc_plus4
- Arithmetic rules:
  - All arithmetic is 32-bit unsigned; carry is dropped, so PC wraps 0xFFFF_FFFC → 0x0000_0000.
  - pc[1:0] is always 00 by construction.
- Inputs outside their windows are ignored:
  - imem_ready outside FETCH.
  - branch_in, zero_in, jump_in, hold_in outside EXEC.
- instr keeps its last value through FETCH; instr_valid=0 there.
- Reset values: imem_req=0, instr_valid=0, instr=0, opcode=000000, pc=imem_addr=RESET_PC, pc_plus4=RESET_PC+4, instr_count=0.

## Timing
- imem_req is a registered-state decode, so it is glitch-free within the cycle.
- Minimum 2 cycles per instruction: FETCH with ready in the same cycle, then EXEC.
- Each ready-wait cycle adds 1 cycle. Each hold_in cycle adds 1 cycle.
- Edge order:
  - Edge ending FETCH (ready=1): instr and state update; instr_valid=1 in the next cycle.
  - Edge ending EXEC (hold_in=0): pc, instr_count and state update; imem_addr shows the new PC in the next cycle.
- rst asserted mid-FETCH drops imem_req the cycle after the reset edge. The outstanding request is abandoned; memory must tolerate this.
- rst asserted in EXEC discards the instruction: pc is not advanced and instr_count is not incremented.
- rst=1 together with imem_ready=1 or hold_in=0: reset wins.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_ADDI=001000, OP_J=000010
  - fetch_state_t enum {RESET, FETCH, EXEC}
  - default reset PC constant
- Natural sub-module: next_pc_logic.
  - Combinational; inputs pc_plus4, imm_ext, instr[25:0], branch_in, zero_in, jump_in; output next_pc.
  - Reused later by a pipelined variant.
- The top level holds the FSM, PC/instr/count registers and handshake outputs.

## Test plan
- Reset then release, memory always ready, instr 0x2008_0005 (addi): cycle 1 imem_req=1 addr=0; cycle 2 instr_valid=1, opcode=001000; cycle 3 addr=4, instr_count=1.
- Memory ready delayed 3 cycles: imem_req and addr=0 held stable for 4 cycles; instr_valid stays 0 until the cycle after ready.
- At pc=0x10, beq with imm_ext=0xFFFF_FFFE: zero_in=1 gives next pc=0x0C; zero_in=0 gives next pc=0x14.
- jump_in=1, pc=0x1000_0040, instr[25:0]=0x000_0100: next pc=0x1000_0400; jump wins when branch_in=zero_in=1.
- hold_in=1 for 2 EXEC cycles: instr_valid=1 for 3 cycles, pc unchanged, instr_count increments once.
- rst asserted mid-FETCH with ready=1 in the same cycle: pc=RESET_PC, instr=0, instr_count=0; imem_req=0 in the next cycle; imem_req=1 in the cycle after rst deasserts.
